// File: rtl/trinity_pkg.sv
// rtl/trinity_pkg.sv - shared constants and state type for the trinity resonance harmonizer
package trinity_pkg;

    localparam int FP_W  = 32;
    localparam int DIV_W = 48;

    // e, pi and phi in unsigned 16.16 fixed point
    localparam logic [FP_W-1:0] FP_E   = 32'h0002B7E1;
    localparam logic [FP_W-1:0] FP_PI  = 32'h0003243F;
    localparam logic [FP_W-1:0] FP_PHI = 32'h00019E37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } harm_state_t;

endpackage

// File: rtl/trinity_fp_divider.sv
// rtl/trinity_fp_divider.sv - restoring divider, one quotient bit per cycle; HARMONIC_SAT_EN saturates the quotient
module trinity_fp_divider
    import trinity_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] dividend,
    input  logic [FP_W-1:0]  divisor,
    output logic             busy,
    output logic             done,
    output logic [FP_W-1:0]  quotient,
    output logic             q_sat
);

    localparam logic [5:0] LAST_STEP = 6'(DIV_W - 1);

    // dividend bits leave at the top while quotient bits enter at the bottom
    logic [DIV_W-1:0] acc_q, acc_d;
    logic [FP_W-1:0]  rem_q, rem_d;
    logic [FP_W-1:0]  dsr_q, dsr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [FP_W:0]    rem_shift;
    logic             q_bit;

    always_comb begin
        rem_shift = {rem_q, acc_q[DIV_W-1]};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        acc_d     = acc_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            acc_d  = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // the true difference is below 2^32, so the low word subtraction is exact
            rem_d = q_bit ? (rem_shift[FP_W-1:0] - dsr_q) : rem_shift[FP_W-1:0];
            acc_d = {acc_q[DIV_W-2:0], q_bit};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_STEP) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST_STEP);

`ifdef HARMONIC_SAT_EN
    assign q_sat    = |acc_q[DIV_W-1:FP_W];
    assign quotient = q_sat ? '1 : acc_q[FP_W-1:0];
`else
    assign q_sat    = 1'b0;
    assign quotient = acc_q[FP_W-1:0];
`endif

endmodule

// File: rtl/trinity_resonance_harmonizer.sv
// rtl/trinity_resonance_harmonizer.sv - Gh = T + e/T in 16.16; HARMONIC_SAT_EN enables saturation
module trinity_resonance_harmonizer
    import trinity_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            lock_in,
    input  logic [FP_W-1:0] t_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] gh_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            div_zero,
    output logic            sat,
    output logic            abort_pulse
);

    harm_state_t     state_q, state_d;
    logic [FP_W-1:0] t_q, t_d;
    logic [FP_W-1:0] gh_q, gh_d;
    logic            dz_q, dz_d;
    logic            sat_q, sat_d;
    logic            abort_q, abort_d;

    logic            accept;
    logic            div_start, div_abort, div_busy, div_done, q_sat;
    logic [FP_W-1:0] quotient;
    logic [FP_W-1:0] sum_val;
    logic            carry;

    assign in_ready  = (state_q == IDLE) && lock_in;
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (t_in != '0);
    assign div_abort = div_busy && !lock_in;

    trinity_fp_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend ({FP_E, 16'h0000}),
        .divisor  (t_in),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient),
        .q_sat    (q_sat)
    );

`ifdef HARMONIC_SAT_EN
    logic [FP_W:0] sum_full;
    assign sum_full = {1'b0, t_q} + {1'b0, quotient};
    assign carry    = sum_full[FP_W];
    assign sum_val  = carry ? '1 : sum_full[FP_W-1:0];
`else
    assign carry    = 1'b0;
    assign sum_val  = t_q + quotient;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        gh_d    = gh_q;
        dz_d    = dz_q;
        sat_d   = sat_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    t_d = t_in;
                    if (t_in == '0) begin
                        gh_d    = '1;
                        dz_d    = 1'b1;
                        sat_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (!lock_in) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (div_done) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (!lock_in) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    gh_d    = sum_val;
                    dz_d    = 1'b0;
                    sat_d   = q_sat | carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                // lock loss is ignored here so a finished result is never dropped
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            gh_q    <= '0;
            dz_q    <= 1'b0;
            sat_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            gh_q    <= gh_d;
            dz_q    <= dz_d;
            sat_q   <= sat_d;
            abort_q <= abort_d;
        end
    end

    assign gh_out      = gh_q;
    assign div_zero    = dz_q;
    assign sat         = sat_q;
    assign abort_pulse = abort_q;
    assign out_valid   = (state_q == DONE);

endmodule

// File: tb/tb_trinity_resonance_harmonizer.sv
// tb/tb_trinity_resonance_harmonizer.sv - scoreboard bench for the harmonizer, honours HARMONIC_SAT_EN
module tb_trinity_resonance_harmonizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lock_in = 1'b1;
    logic [31:0] t_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] gh_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        div_zero;
    logic        sat;
    logic        abort_pulse;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] gh;
        logic        dz;
        logic        sat;
    } exp_t;

    exp_t sb[$];

    trinity_resonance_harmonizer dut (
        .clk         (clk),
        .reset       (reset),
        .lock_in     (lock_in),
        .t_in        (t_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .gh_out      (gh_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .div_zero    (div_zero),
        .sat         (sat),
        .abort_pulse (abort_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] t);
        exp_t        e;
        logic [63:0] q;
        logic [32:0] s;
        if (t == 32'h0) begin
            e.gh = 32'hFFFFFFFF; e.dz = 1'b1; e.sat = 1'b0;
            return e;
        end
        q = (64'h0002B7E1 << 16) / {32'h0, t};
        e.dz = 1'b0;
`ifdef HARMONIC_SAT_EN
        e.sat = (q[63:32] != 32'h0);
        if (e.sat) q = 64'hFFFFFFFF;
        s = {1'b0, t} + {1'b0, q[31:0]};
        if (s[32]) begin
            e.sat = 1'b1;
            e.gh  = 32'hFFFFFFFF;
        end else begin
            e.gh = s[31:0];
        end
`else
        s = {1'b0, t} + {1'b0, q[31:0]};
        e.gh  = s[31:0];
        e.sat = 1'b0;
`endif
        return e;
    endfunction

    // leaves the bench at the negedge of cycle N+1
    task automatic issue(input logic [31:0] t, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL issue_ready in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        t_in = t;
        if (push) sb.push_back(model(t));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        t_in = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_scoreboard empty queue with out_valid=%b", name, out_valid);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (gh_out !== e.gh) begin
            failures++;
            $display("FAIL %s_gh got=%h required=%h", name, gh_out, e.gh);
        end
        checks++;
        if ({div_zero, sat} !== {e.dz, e.sat}) begin
            failures++;
            $display("FAIL %s_flags got dz=%b sat=%b required dz=%b sat=%b", name, div_zero, sat, e.dz, e.sat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_release got out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lock_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, div_zero, sat, abort_pulse, in_ready} !== 5'b00001 || gh_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got ov=%b dz=%b sat=%b ab=%b rdy=%b gh=%h required 0 0 0 0 1 0",
                     out_valid, div_zero, sat, abort_pulse, in_ready, gh_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_value(input string name, input logic [31:0] t, input int exp_lat);
        int lat;
        issue(t, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=%0d", name, lat, exp_lat);
        end
        pop_check(name);
    endtask

    task automatic test_reset_mid_div();
        bit seen = 1'b0;
        issue(32'h00020000, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, div_zero, sat, abort_pulse} !== 4'b0000 || gh_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_div got ov=%b dz=%b sat=%b ab=%b gh=%h required all 0",
                     out_valid, div_zero, sat, abort_pulse, gh_out);
        end
        reset = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_div_no_output got out_valid=1 required=0");
        end
    endtask

    task automatic test_stall();
        int          lat;
        logic [31:0] g;
        bit          bad = 1'b0;
        issue(32'h00030000, 1'b1);
        wait_valid(lat);
        g = gh_out;
        repeat (10) begin
            @(negedge clk);
            if (gh_out !== g || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL stall_hold got gh=%h in_ready=%b out_valid=%b required gh=%h 0 1", gh_out, in_ready, out_valid, g);
        end
        pop_check("stall");
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        issue(32'h000DD14C, 1'b0);
        repeat (19) @(negedge clk);
        lock_in = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready_low got=%b required=0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (abort_pulse !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_pulse got ab=%b ov=%b required 1 0", abort_pulse, out_valid);
        end
        @(negedge clk);
        checks++;
        if (abort_pulse !== 1'b0) begin
            failures++;
            $display("FAIL abort_one_cycle got=%b required=0", abort_pulse);
        end
        repeat (60) begin
            @(negedge clk);
            if (out_valid || in_ready) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_quiet got out_valid/in_ready activity required none");
        end
        lock_in = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sb.size() != 0) begin
            failures++;
            $display("FAIL abort_recover got in_ready=%b queue=%0d required 1 0", in_ready, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            t = (i % 2 == 0) ? $urandom : ($urandom & 32'h0000FFFF);
            if (t == 32'h0) t = 32'h00000123;
            issue(t, 1'b1);
            wait_valid(lat);
            checks++;
            if (lat !== 50) begin
                failures++;
                $display("FAIL b2b_latency_%0d got=%0d required=50", i, lat);
            end
            pop_check("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_value("basic", 32'h000DD14C, 50);
        test_value("unit", 32'h00010000, 50);
        test_value("tiny", 32'h00000001, 50);
        test_value("zero", 32'h00000000, 1);
        test_reset_mid_div();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trinity_resonance_harmonizer.md
TRINITY_RESONANCE_HARMONIZER -- requirements
Module: trinity_resonance_harmonizer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port lock_in, input, 1, resonance lock from the upstream resonator.
REQ-004 SHALL have port t_in, input, 32, cosmic scalar T in unsigned 16.16 fixed-point.
REQ-005 SHALL have port in_valid, input, 1, t_in valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts t_in.
REQ-007 SHALL have port gh_out, output, 32, Gh = T + e/T in unsigned 16.16.
REQ-008 SHALL have port out_valid, output, 1, gh_out valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts gh_out.
REQ-010 SHALL have port div_zero, output, 1, current result came from T == 0.
REQ-011 SHALL have port sat, output, 1, current result was saturated.
REQ-012 SHALL have port abort_pulse, output, 1, one-cycle pulse on loss-of-lock abort.

Function
REQ-013 SHALL use FSM states IDLE, DIV, ADD, DONE.
REQ-014 SHALL drive in_ready = (state == IDLE) && lock_in, combinationally.
REQ-015 SHALL capture t_in on the in_valid && in_ready cycle N and enter DIV, or enter DONE if t_in == 0.
REQ-016 SHALL compute q = floor((FP_E << 16) / T) by restoring division: 48-bit dividend, one quotient bit per cycle, 48 DIV cycles (N+1..N+48).
REQ-017 SHALL set q to 32'hFFFFFFFF and flag saturation when quotient bits [47:32] are non-zero.
REQ-018 SHALL form gh_out = T + q in ADD (cycle N+49), saturating to 32'hFFFFFFFF on carry-out.
REQ-019 SHALL assert out_valid from cycle N+50, or from N+1 for T == 0, and hold gh_out, div_zero and sat stable until out_valid && out_ready.
REQ-020 SHALL return to IDLE on the cycle after the out_valid && out_ready handshake; back-to-back acceptance is therefore possible one cycle after the output handshake.
REQ-021 SHALL, for T == 0, output gh_out = 32'hFFFFFFFF, div_zero = 1, sat = 0.
REQ-022 SHALL, on lock_in low during DIV or ADD, discard the result, pulse abort_pulse for one cycle, and return to IDLE.
REQ-023 SHALL ignore lock_in while in DONE: a computed result is always delivered.
REQ-024 SHALL ignore in_valid outside IDLE; no input buffering.

Reset
REQ-025 SHALL, on reset, enter IDLE and set gh_out = 0, out_valid = 0, div_zero = 0, sat = 0, abort_pulse = 0, and clear the divider registers.
REQ-026 SHALL let reset override every state, including mid-DIV, with no output produced.

Configuration
REQ-027 SHALL, with HARMONIC_SAT_EN defined, saturate as in REQ-017 and REQ-018 and drive sat.
REQ-028 SHALL, without HARMONIC_SAT_EN, truncate q to its low 32 bits, wrap the addition modulo 2^32, and tie sat to 0; the T == 0 behaviour is unchanged.

Structure
REQ-029 SHALL take from package trinity_pkg:
- FP_E = 32'h0002B7E1
- FP_PI and FP_PHI
- FP_W = 32, DIV_W = 48
- state typedef harm_state_t
REQ-030 SHALL place the iterative divider in sub-module trinity_fp_divider, with start/busy/done signalling, instantiated once.

Verification
REQ-031 SHALL cover: t_in = 32'h000DD14C with lock_in = 1 -> q = 32'h0000325C, gh_out = 32'h000E03A8, out_valid at N+50, div_zero = 0, sat = 0.
REQ-032 SHALL cover: t_in = 32'h00010000 -> gh_out = 32'h0003B7E1.
REQ-033 SHALL cover: t_in = 32'h00000001 with HARMONIC_SAT_EN -> gh_out = 32'hFFFFFFFF, sat = 1; without the macro -> gh_out = 32'hB7E10001, sat = 0.
REQ-034 SHALL cover: t_in = 0 -> out_valid at N+1, gh_out = 32'hFFFFFFFF, div_zero = 1.
REQ-035 SHALL cover: lock_in dropped at N+20 -> abort_pulse at N+21, no out_valid, in_ready high again once lock_in returns.
REQ-036 SHALL cover: out_ready held low for 10 cycles after out_valid -> gh_out stable and in_ready low throughout; reset asserted mid-DIV -> all outputs return to 0 on the next cycle.
